// File: rtl/xrv_ifq.sv
// xrv_ifq: instruction fetch queue between the instruction memory port and decode.
// Pipelined request/response fetch with DEPTH credits; each word is tagged with its PC.
// A redirect (jmp) flushes the queue and discards every response still outstanding.
//
// Latency: response to inst_valid is 1 cycle; 0 cycles when XRV_IFQ_BYPASS_EN is defined.
// Backpressure: inst_ready low holds the head entry. Fetch stops issuing once
// count + inflight reaches DEPTH, so a response always has a free slot.
//
// Optional feature macro: XRV_IFQ_BYPASS_EN. When defined, a response that arrives
// while the queue is empty is presented to decode in the same cycle.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   jmp, jmp_addr                redirect request and target (bits [1:0] ignored)
//   i_req, i_addr, i_ready       fetch request channel to memory
//   i_rvalid, i_data             in-order response channel from memory
//   inst_valid, inst, inst_pc    head instruction to decode
//   inst_ready                   decode consumes head
//   occupancy                    entries currently stored
module xrv_ifq #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jmp,
  input  logic [31:0]                jmp_addr,
  output logic                       i_req,
  output logic [31:0]                i_addr,
  input  logic                       i_ready,
  input  logic                       i_rvalid,
  input  logic [31:0]                i_data,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  input  logic                       inst_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int          CW     = $clog2(DEPTH + 1);
  localparam int          PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] RST_PC = RESET_PC & 32'hFFFF_FFFC;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic          run_q, run_d;
  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_inst_d [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_pc_d   [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [31:0] jmp_tgt;
  logic [CW:0] credit_used;
  logic        accept;
  logic        rsp_dec;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        head_vld;
  logic        byp_vld;
  logic        byp_take;
  logic        push;
  logic        pop;

  always_comb begin
    jmp_tgt     = jmp_addr & 32'hFFFF_FFFC;
    // Every queued entry and every outstanding request (including ones already
    // marked for discard) holds a credit, so a response can never find the queue full.
    credit_used = {1'b0, count_q} + {1'b0, inflight_q};
    i_req       = run_q & ~jmp & (credit_used < (CW+1)'(DEPTH));
    i_addr      = fetch_pc_q;
    accept      = i_req & i_ready;

    // A response with nothing outstanding is a memory protocol error; it is not
    // allowed to wrap the counter.
    rsp_dec     = i_rvalid & (inflight_q != '0);
    rsp_drop    = i_rvalid & (jmp | (discard_q != '0));
    rsp_keep    = i_rvalid & ~rsp_drop;

    head_vld    = (count_q != '0);
  end

`ifdef XRV_IFQ_BYPASS_EN
  // rsp_keep already excludes jmp and pending discards.
  always_comb begin
    byp_vld  = ~head_vld & rsp_keep;
    byp_take = byp_vld & inst_ready;
    inst_valid = head_vld | byp_vld;
    if (byp_vld) begin
      inst    = i_data;
      inst_pc = rsp_pc_q;
    end else begin
      inst    = mem_inst_q[rd_ptr_q];
      inst_pc = mem_pc_q[rd_ptr_q];
    end
  end
`else
  always_comb begin
    byp_vld    = 1'b0;
    byp_take   = 1'b0;
    inst_valid = head_vld;
    inst       = mem_inst_q[rd_ptr_q];
    inst_pc    = mem_pc_q[rd_ptr_q];
  end
`endif

  always_comb begin
    // A word consumed straight off the bypass path never occupies a slot.
    push      = rsp_keep & ~byp_take;
    // The head pop is ignored during a redirect; the flush wins.
    pop       = head_vld & inst_ready & ~jmp;
    occupancy = count_q;
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    run_d      = 1'b1;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(rsp_dec);
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (jmp) begin
      fetch_pc_d = jmp_tgt;
      rsp_pc_d   = jmp_tgt;
      // inflight already includes requests marked for discard, so after a
      // redirect the discard count is simply everything still outstanding once
      // this cycle's response (if any) has been retired. This also makes
      // back-to-back redirects accumulate correctly.
      discard_d  = inflight_q - CW'(rsp_dec);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (i_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    mem_inst_d = mem_inst_q;
    mem_pc_d   = mem_pc_q;
    if (push) begin
      mem_inst_d[wr_ptr_q] = i_data;
      mem_pc_d[wr_ptr_q]   = rsp_pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RST_PC;
      rsp_pc_q   <= RST_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else begin
      run_q      <= run_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mem_inst_q <= mem_inst_d;
      mem_pc_q   <= mem_pc_d;
    end
  end

endmodule

// File: tb/tb_xrv_ifq.sv
// tb_xrv_ifq: bench for xrv_ifq (DEPTH=4, RESET_PC=0).
// A memory model returns words in request order after a programmable latency; a
// reference model tracks the expected decode stream with epochs per redirect.
module tb_xrv_ifq;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef XRV_IFQ_BYPASS_EN
  localparam int          SKEW     = 1;
`else
  localparam int          SKEW     = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  occupancy;

  xrv_ifq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .jmp(jmp), .jmp_addr(jmp_addr),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
    .i_rvalid(i_rvalid), .i_data(i_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  req_t        pend[$];   // requests accepted by memory, not yet answered
  ent_t        mq[$];     // instructions decode must still see, in order
  int          cyc     = 0;
  int          epoch   = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          run_m   = 1'b0;
  logic [31:0] fetch_m = RESET_PC;
  int          checks  = 0;
  int          errors  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model and per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin : mon
    bit   exp_req, good, byp, exp_v, take;
    ent_t e, cur;
    req_t r;
    if (rst) begin
      chk("rst_i_req", i_req, 1'b0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_occupancy", occupancy, 32'd0);
      mq.delete();
      pend.delete();
      run_m   = 1'b0;
      fetch_m = RESET_PC;
    end else begin
      exp_req = run_m && !jmp && ((mq.size() + pend.size()) < DEPTH);
      chk("i_req", i_req, exp_req);
      chk("i_addr", i_addr, fetch_m);

      good   = 1'b0;
      e.pc   = '0;
      e.word = '0;
      if (i_rvalid && pend.size() != 0) begin
        good   = (pend[0].ep == epoch) && !jmp;
        e.pc   = pend[0].addr;
        e.word = mem_word(pend[0].addr);
      end
      byp = 1'b0;
`ifdef XRV_IFQ_BYPASS_EN
      byp = good && (mq.size() == 0);
`endif
      exp_v = (mq.size() != 0) || byp;
      chk("inst_valid", inst_valid, exp_v);
      chk("occupancy", occupancy, mq.size());
      if (exp_v) begin
        cur = (mq.size() != 0) ? mq[0] : e;
        chk("inst", inst, cur.word);
        chk("inst_pc", inst_pc, cur.pc);
      end

      if (jmp) begin
        mq.delete();
        epoch++;
        fetch_m = jmp_addr & 32'hFFFF_FFFC;
      end else begin
        take = exp_v && inst_ready;
        if (take && mq.size() != 0) void'(mq.pop_front());
        if (good && !(take && byp)) mq.push_back(e);
      end

      if (i_rvalid && pend.size() != 0) void'(pend.pop_front());
      if (i_req && i_ready) begin
        r.addr = i_addr;
        r.due  = cyc + int'($urandom_range(lat_max, lat_min));
        r.ep   = epoch;
        pend.push_back(r);
        if (!jmp) fetch_m = fetch_m + 32'd4;
      end
      run_m = 1'b1;
    end
  end

  // Advance to just after the next rising edge and drive the memory response.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    jmp = 1'b0;
    if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
      i_rvalid = 1'b1;
      i_data   = mem_word(pend[0].addr);
    end else begin
      i_rvalid = 1'b0;
      i_data   = $urandom;
    end
  endtask

  // Steps past the current cycle, then waits for the first valid head.
  task automatic wait_valid(output logic [31:0] pc, output bit ok);
    ok = 1'b0;
    pc = '0;
    step();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        ok = 1'b1;
        pc = inst_pc;
        break;
      end
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : drive
    logic [31:0] pc;
    bit          ok;
    bit          found;

    rst        = 1'b1;
    jmp        = 1'b0;
    jmp_addr   = '0;
    i_ready    = 1'b1;
    i_rvalid   = 1'b0;
    i_data     = '0;
    inst_ready = 1'b1;

    // Reset values.
    step();
    step();
    chk("reset_i_req", i_req, 1'b0);
    chk("reset_i_addr", i_addr, RESET_PC);
    chk("reset_inst_valid", inst_valid, 1'b0);
    chk("reset_inst", inst, 32'h0);
    chk("reset_inst_pc", inst_pc, 32'h0);
    chk("reset_occupancy", occupancy, 32'd0);

    // Zero-wait memory, decode always ready.
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_delay", i_req, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step();
      @(negedge clk);
      chk("stream_i_req", i_req, 1'b1);
      chk("stream_i_addr", i_addr, 32'(4 * k));
      if (k >= SKEW) begin
        chk("stream_valid", inst_valid, 1'b1);
        chk("stream_inst_pc", inst_pc, 32'(4 * (k - SKEW)));
      end
    end

    // Decode stall for 10 cycles, then drain.
    for (int k = 0; k < 10; k++) begin
      step();
      inst_ready = 1'b0;
    end
    @(negedge clk);
    chk("stall_occupancy_full", occupancy, 32'd4);
    chk("stall_i_req_low", i_req, 1'b0);
    step();
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();

    // Latency 3, redirect with three requests outstanding.
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (pend.size() == 3) found = 1'b1;
    end
    chk("lat3_inflight_reached", found, 1'b1);
    jmp      = 1'b1;
    jmp_addr = 32'h0000_0100;
    wait_valid(pc, ok);
    chk("lat3_redirect_seen", ok, 1'b1);
    chk("lat3_first_pc", pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop; unaligned target.
    lat_min = 1;
    lat_max = 1;
    found   = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      inst_ready = (i < 2) ? 1'b0 : 1'b1;
      if (i_rvalid && occupancy != 0) found = 1'b1;
    end
    chk("coincide_setup", found, 1'b1);
    jmp        = 1'b1;
    jmp_addr   = 32'h0000_0203;
    inst_ready = 1'b1;
    @(negedge clk);
    chk("coincide_i_req_low", i_req, 1'b0);
    step();
    @(negedge clk);
    chk("coincide_occupancy", occupancy, 32'd0);
    chk("coincide_i_req", i_req, 1'b1);
    chk("coincide_i_addr", i_addr, 32'h0000_0200);

    // Back-to-back redirects with two requests outstanding.
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (pend.size() == 2) found = 1'b1;
    end
    chk("b2b_setup", found, 1'b1);
    jmp      = 1'b1;
    jmp_addr = 32'h0000_0040;
    step();
    jmp      = 1'b1;
    jmp_addr = 32'h0000_0080;
    wait_valid(pc, ok);
    chk("b2b_redirect_seen", ok, 1'b1);
    chk("b2b_first_pc", pc, 32'h0000_0080);

    // Reset asserted mid-stream with three entries queued.
    lat_min    = 1;
    lat_max    = 1;
    inst_ready = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      inst_ready = 1'b0;
      if (occupancy == 3) found = 1'b1;
    end
    chk("midrst_setup", found, 1'b1);
    rst      = 1'b1;
    i_rvalid = 1'b0;
    #1;
    chk("midrst_i_req", i_req, 1'b0);
    chk("midrst_i_addr", i_addr, RESET_PC);
    chk("midrst_inst_valid", inst_valid, 1'b0);
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_inst_pc", inst_pc, 32'h0);
    chk("midrst_occupancy", occupancy, 32'd0);
    inst_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("restart_wait", i_req, 1'b0);
    step();
    @(negedge clk);
    chk("restart_i_req", i_req, 1'b1);
    chk("restart_i_addr", i_addr, RESET_PC);

    // Randomized traffic: variable latency, ready gaps and redirects.
    lat_min = 1;
    lat_max = 5;
    for (int k = 0; k < 3000; k++) begin
      step();
      i_ready    = ($urandom_range(3, 0) != 0);
      inst_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(19, 0) == 0) begin
        jmp      = 1'b1;
        jmp_addr = $urandom;
      end
    end
    step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
